// File: rtl/psiso_tx_ctrl.sv
// Two-requester parallel-in / serial-out transmit controller.
// A round-robin arbiter picks one requester in IDLE, loads its word and
// sends it LSB first over WIDTH cycles. GAP idle cycles follow each frame.
// All outputs come straight from flops.
module psiso_tx_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0,
    input  logic [WIDTH-1:0] i_data0,
    input  logic             i_req1,
    input  logic [WIDTH-1:0] i_data1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_q,
    output logic             o_valid,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_src
);

    // One counter serves both the bit index in SHIFT and the idle count in GAP.
    localparam int CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             src_q, src_d;
    logic             arb_seen_q, arb_seen_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             q_q, q_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             win_s;

    // Round-robin winner; before the first grant requester 0 has priority.
    always_comb begin
        win_s = 1'b0;
        if (i_req0 && i_req1) begin
            if (arb_seen_q) begin
                win_s = ~src_q;
            end else begin
                win_s = 1'b0;
            end
        end else if (i_req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state logic plus the next values of every registered output.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        arb_seen_d = arb_seen_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req0 || i_req1) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = '0;
                    src_d      = win_s;
                    arb_seen_d = 1'b1;
                    sr_d       = win_s ? i_data1 : i_data0;
                    gnt0_d     = ~win_s;
                    gnt1_d     = win_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
                if (cnt_q == BIT_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sr_d    = '0;
            end
        endcase
        valid_d = (state_d == ST_SHIFT);
        q_d     = valid_d ? sr_d[0] : 1'b0;
        done_d  = valid_d && (cnt_d == BIT_LAST);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            src_q      <= 1'b0;
            arb_seen_q <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            q_q        <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            arb_seen_q <= arb_seen_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            q_q        <= q_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign o_gnt0  = gnt0_q;
    assign o_gnt1  = gnt1_q;
    assign o_q     = q_q;
    assign o_valid = valid_q;
    assign o_done  = done_q;
    assign o_busy  = busy_q;
    assign o_src   = src_q;

endmodule

// File: tb/tb_psiso_tx_ctrl.sv
// Self-checking bench for psiso_tx_ctrl (WIDTH=4, GAP=1).
// A frame-level model predicts every output each cycle; directed scenarios
// add literal expectations for bit order, grant order and spacing, and reset.
module tb_psiso_tx_ctrl;

    localparam int W = 4;
    localparam int G = 1;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_req0 = 1'b0;
    logic [W-1:0] i_data0 = '0;
    logic         i_req1 = 1'b0;
    logic [W-1:0] i_data1 = '0;
    logic         o_gnt0, o_gnt1, o_q, o_valid, o_done, o_busy, o_src;

    psiso_tx_ctrl #(.WIDTH(W), .GAP(G)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_req0 (i_req0),
        .i_data0(i_data0),
        .i_req1 (i_req1),
        .i_data1(i_data1),
        .o_gnt0 (o_gnt0),
        .o_gnt1 (o_gnt1),
        .o_q    (o_q),
        .o_valid(o_valid),
        .o_done (o_done),
        .o_busy (o_busy),
        .o_src  (o_src)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    // ---------------- frame-level model ----------------
    // A frame lasts W bit phases followed by G gap phases after the grant edge.
    logic         m_active;
    int           m_phase;
    logic [W-1:0] m_word;
    logic         m_src;
    logic         m_seen;

    function automatic logic rr_pick(logic r0, logic r1, logic seen, logic last);
        if (r0 && r1) return seen ? ~last : 1'b0;
        return r1;
    endfunction

    // Advance the model on each edge; reset clears it immediately.
    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_active <= 1'b0;
            m_phase  <= 0;
            m_word   <= '0;
            m_src    <= 1'b0;
            m_seen   <= 1'b0;
        end else if (!m_active) begin
            if (i_req0 || i_req1) begin
                m_active <= 1'b1;
                m_phase  <= 0;
                m_src    <= rr_pick(i_req0, i_req1, m_seen, m_src);
                m_word   <= rr_pick(i_req0, i_req1, m_seen, m_src) ? i_data1 : i_data0;
                m_seen   <= 1'b1;
            end
        end else if (m_phase == W + G - 1) begin
            m_active <= 1'b0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    // ---------------- checking infrastructure ----------------
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_done = 0;
    logic qbits[$];
    int   gnt_cyc[$];
    int   gnt_id[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: sample at the falling edge, compare with the model, log events.
    task automatic tick();
        logic ev, eq, ed;
        @(negedge i_clk);
        cyc++;
        ev = m_active && (m_phase < W);
        eq = ev ? m_word[m_phase] : 1'b0;
        ed = ev && (m_phase == W - 1);
        check("valid", int'(o_valid), int'(ev));
        check("q", int'(o_q), int'(eq));
        check("done", int'(o_done), int'(ed));
        check("gnt0", int'(o_gnt0), int'(m_active && m_phase == 0 && !m_src));
        check("gnt1", int'(o_gnt1), int'(m_active && m_phase == 0 && m_src));
        check("busy", int'(o_busy), int'(m_active));
        check("src", int'(o_src), int'(m_src));
        check("gnt_excl", int'(o_gnt0 & o_gnt1), 0);
        if (o_valid) qbits.push_back(o_q);
        if (o_gnt0 || o_gnt1) begin
            gnt_cyc.push_back(cyc);
            gnt_id.push_back(int'(o_gnt1));
        end
        if (o_done) n_done++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Wait (bounded) for the next grant; returns requester id and cycle.
    task automatic wait_grant(output int id, output int gc);
        int  n0;
        bit  got;
        n0  = gnt_id.size();
        got = 1'b0;
        id  = -1;
        gc  = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (gnt_id.size() > n0) begin
                got = 1'b1;
                id  = gnt_id[n0];
                gc  = gnt_cyc[n0];
            end
        end
        check("grant_timeout", int'(got), 1);
    endtask

    function automatic int frame_bits(input int s);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) begin
            if (s + i < qbits.size()) v[i] = qbits[s + i];
        end
        return int'(v);
    endfunction

    task automatic check_all_zero(input string name);
        check(name, int'({o_gnt0, o_gnt1, o_q, o_valid, o_done, o_busy, o_src}), 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        ticks(2);
        check_all_zero("reset_state");
        i_rst = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int id, gc, id2, gc2, qs, nd;
        int exp_id[4];
        exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 0; exp_id[3] = 1;

        #1 i_rst = 1'b0;
        do_reset();

        // Single frame from requester 0: bits 1,1,0,1 then one gap cycle.
        i_req0  = 1'b1;
        i_data0 = 4'b1011;
        qs = qbits.size();
        nd = n_done;
        wait_grant(id, gc);
        check("t1_gnt_id", id, 0);
        check("t1_src", int'(o_src), 0);
        i_req0 = 1'b0;
        ticks(5);
        check("t1_nbits", qbits.size() - qs, 4);
        check("t1_bits", frame_bits(qs), 4'b1011);
        check("t1_ndone", n_done - nd, 1);
        check("t1_idle", int'(o_busy), 0);

        // Both requesting right after reset: 0 first, then 1.
        i_req0  = 1'b1;
        i_req1  = 1'b1;
        i_data0 = 4'b0101;
        i_data1 = 4'b0011;
        do_reset();
        wait_grant(id, gc);
        check("t2_first", id, 0);
        i_req0 = 1'b0;
        wait_grant(id2, gc2);
        check("t2_second", id2, 1);
        check("t2_spacing", gc2 - gc, 6);
        i_req1 = 1'b0;
        ticks(6);

        // Both held continuously: grants alternate with period 6.
        i_req0 = 1'b1;
        i_req1 = 1'b1;
        gc = -1;
        for (int g = 0; g < 4; g++) begin
            wait_grant(id2, gc2);
            check("t3_order", id2, exp_id[g]);
            if (g > 0) check("t3_spacing", gc2 - gc, 6);
            gc = gc2;
        end
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        ticks(8);

        // Data change and new request during SHIFT do not disturb the frame.
        i_req0  = 1'b1;
        i_data0 = 4'b1001;
        qs = qbits.size();
        wait_grant(id, gc);
        check("t4_first", id, 0);
        i_req0  = 1'b0;
        i_data0 = 4'b0110;
        i_req1  = 1'b1;
        i_data1 = 4'b1110;
        wait_grant(id2, gc2);
        check("t4_second", id2, 1);
        check("t4_spacing", gc2 - gc, 6);
        check("t4_bits0", frame_bits(qs), 4'b1001);
        i_req1 = 1'b0;
        ticks(6);
        check("t4_bits1", frame_bits(qs + 4), 4'b1110);

        // Reset after the second bit aborts the frame; grant right after release.
        i_req0  = 1'b1;
        i_data0 = 4'b1111;
        nd = n_done;
        wait_grant(id, gc);
        check("t5_first", id, 0);
        i_req0 = 1'b0;
        tick();
        check("t5_bit2_valid", int'(o_valid), 1);
        @(posedge i_clk);
        #2;
        i_rst   = 1'b0;
        i_req1  = 1'b1;
        i_data1 = 4'b0110;
        #1;
        check_all_zero("t5_async_clear");
        tick();
        i_rst = 1'b1;
        qs = qbits.size();
        tick();
        check("t5_gnt1_first_edge", int'(o_gnt1), 1);
        i_req1 = 1'b0;
        ticks(6);
        check("t5_bits", frame_bits(qs), 4'b0110);
        check("t5_ndone", n_done - nd, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
